// File: rtl/cal_sequencer_if.sv
// Signal bundle between the calibration sequencer, its host and the clock divider.
// The slave view belongs to the sequencer; the master view belongs to whoever drives it.
interface cal_sequencer_if #(
    parameter int LEN_W = 12
);
    logic             start;
    logic             abort;
    logic [5:0]       divcount_in;
    logic [LEN_W-1:0] burst_len;
    logic             div_clkout;
    logic             div_load;
    logic [5:0]       div_divcount;
    logic             cal_en;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  start, abort, divcount_in, burst_len, div_clkout,
        output div_load, div_divcount, cal_en, busy, done, err
    );

    modport master (
        output start, abort, divcount_in, burst_len, div_clkout,
        input  div_load, div_divcount, cal_en, busy, done, err
    );
endinterface

// File: rtl/cal_sequencer.sv
// Calibration burst sequencer: loads a divide value into an external divider,
// waits for it to settle, then opens a glitch-free gate for exactly burst_len
// full divider pulses. Every output comes straight from a flop.
module cal_sequencer #(
    parameter int LEN_W      = 12,
    parameter int SETTLE_CYC = 4
) (
    input  logic           clkin,
    input  logic           reset,
    cal_sequencer_if.slave bus
);
    // Settle counter is preloaded with its last index so SETTLE lasts SETTLE_CYC cycles.
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [LEN_W-1:0] CNT_ONE     = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_ARM,
        S_RUN,
        S_TAIL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       settle_q, settle_d;
    logic [5:0]       divcount_q, divcount_d;
    logic             div_prev_q;
    logic             div_load_q, cal_en_q, busy_q, done_q, err_q;
    logic             err_d;
    logic             div_rise;

    // Divider output is synchronous to clkin, so one flop is enough for edge detection.
    assign div_rise = ~div_prev_q & bus.div_clkout;

    // Next-state, counter and latch logic; abort outranks everything outside IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        divcount_d = divcount_q;
        err_d      = 1'b0;
        if (state_q != S_IDLE && bus.abort) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // abort together with start suppresses both the burst and err
                    if (bus.start && !bus.abort) begin
                        if (bus.divcount_in == '0 || bus.burst_len == '0) begin
                            err_d = 1'b1;
                        end else begin
                            divcount_d = bus.divcount_in;
                            cnt_d      = bus.burst_len;
                            state_d    = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    settle_d = SETTLE_LAST;
                    state_d  = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = S_ARM;
                    end else begin
                        settle_d = settle_q - 8'd1;
                    end
                end
                S_ARM: begin
                    // open the gate only while the divider is low: no truncated first pulse
                    if (!bus.div_clkout) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (div_rise && cal_en_q && cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_d = S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    // keep the gate open until the last pulse has fallen
                    if (!bus.div_clkout) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            settle_q   <= '0;
            divcount_q <= '0;
            div_prev_q <= 1'b0;
            div_load_q <= 1'b0;
            cal_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            settle_q   <= settle_d;
            divcount_q <= divcount_d;
            div_prev_q <= bus.div_clkout;
            div_load_q <= (state_d == S_LOAD);
            cal_en_q   <= (state_d == S_RUN) || (state_d == S_TAIL);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            err_q      <= err_d;
        end
    end

    assign bus.div_load     = div_load_q;
    assign bus.div_divcount = divcount_q;
    assign bus.cal_en       = cal_en_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;

endmodule
